// File: rtl/conv_seq_pkg.sv
// Shared types and instruction-word layout for the convolution tile sequencer.
package conv_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_FETCH,
    S_W_LOAD,
    S_W_HOLD,
    S_W_END,
    S_A_FETCH,
    S_EXEC,
    S_WB,
    S_ACC_CLR,
    S_ACC_RD,
    S_DONE
  } state_t;

  localparam int unsigned INST_W     = 34;
  localparam int unsigned B_ACC      = 33;
  localparam int unsigned B_CEN_P    = 32;
  localparam int unsigned B_WEN_P    = 31;
  localparam int unsigned B_AP_LSB   = 20;
  localparam int unsigned B_CEN_X    = 19;
  localparam int unsigned B_WEN_X    = 18;
  localparam int unsigned B_AX_LSB   = 7;
  localparam int unsigned B_OFIFO_RD = 6;
  localparam int unsigned B_IFIFO_WR = 5;
  localparam int unsigned B_IFIFO_RD = 4;
  localparam int unsigned B_L0_RD    = 3;
  localparam int unsigned B_L0_WR    = 2;
  localparam int unsigned B_EXEC     = 1;
  localparam int unsigned B_LOAD     = 0;

  localparam logic [INST_W-1:0] IDLE_INST = 34'h1_800C_0000;

endpackage

// File: rtl/conv_seq_addrgen.sv
// Accumulation address generator: nested (oy, ox, ky, kx) counters, kx innermost.
module conv_seq_addrgen #(
  parameter int IN_W = 6,
  parameter int K    = 3,
  parameter int AW   = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          step,
  output logic [AW-1:0] addr,
  output logic          last
);

  localparam int O_W           = IN_W - K + 1;
  localparam int LEN_NIJ       = IN_W * IN_W;
  localparam logic [7:0] K_END = 8'(K - 1);
  localparam logic [7:0] O_END = 8'(O_W - 1);

  logic [7:0] oy, ox, ky, kx;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      oy <= '0;
      ox <= '0;
      ky <= '0;
      kx <= '0;
    end else if (step) begin
      if (kx == K_END) begin
        kx <= '0;
        if (ky == K_END) begin
          ky <= '0;
          if (ox == O_END) begin
            ox <= '0;
            oy <= (oy == O_END) ? '0 : oy + 8'd1;
          end else begin
            ox <= ox + 8'd1;
          end
        end else begin
          ky <= ky + 8'd1;
        end
      end else begin
        kx <= kx + 8'd1;
      end
    end
  end

  assign addr = AW'((32'(oy) + 32'(ky)) * 32'(IN_W) + 32'(ox) + 32'(kx)
                    + (32'(ky) * 32'(K) + 32'(kx)) * 32'(LEN_NIJ));
  assign last = (kx == K_END) && (ky == K_END) && (ox == O_END) && (oy == O_END);

endmodule

// File: rtl/conv_sequencer.sv
// Instruction sequencer for one 3-phase convolution tile on core.
// Define CONV_SEQ_ACC_EN to include the output accumulation phases.
module conv_sequencer
  import conv_seq_pkg::*;
#(
  parameter int ROW    = 8,
  parameter int COL    = 8,
  parameter int IN_W   = 6,
  parameter int K      = 3,
  parameter int GAP    = 10,
  parameter int AW     = 11,
  parameter int W_BASE = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        acc_clr,
  output logic        out_strobe,
  output logic        busy,
  output logic        done
);

  localparam int LEN_NIJ = IN_W * IN_W;
  localparam int LEN_KIJ = K * K;

  localparam logic [15:0] T_COL_END  = 16'(COL - 1);
  localparam logic [15:0] T_HOLD_END = 16'(COL + GAP - 1);
  localparam logic [15:0] T_AF_END   = 16'(LEN_NIJ);
  localparam logic [15:0] T_EX_END   = 16'(LEN_NIJ + ROW + COL - 1);
  localparam logic [15:0] T_WB_END   = 16'(LEN_NIJ - 1);
  localparam logic [7:0]  KIJ_LAST   = 8'(LEN_KIJ - 1);

  state_t        state;
  logic [15:0]   t;
  logic [7:0]    kij;
  logic [33:0]   word;

`ifdef CONV_SEQ_ACC_EN
  localparam logic [15:0] T_ACC_END = 16'(LEN_KIJ);

  logic          acc_step, acc_last, strobe_pend, final_px;
  logic [AW-1:0] acc_addr;

  assign acc_step = (state == S_ACC_RD) && (t < T_ACC_END);

  conv_seq_addrgen #(.IN_W(IN_W), .K(K), .AW(AW)) u_addrgen (
    .clk   (clk),
    .reset (reset),
    .clr   (state == S_IDLE),
    .step  (acc_step),
    .addr  (acc_addr),
    .last  (acc_last)
  );
`else
  assign acc_clr    = 1'b0;
  assign out_strobe = 1'b0;
`endif

  // Word for the current (state, t); registered into inst below.
  always_comb begin
    word = IDLE_INST;
    case (state)
      S_W_FETCH: begin
        word[B_CEN_X]           = 1'b0;
        word[B_AX_LSB +: AW]    = AW'(W_BASE) + AW'(kij) * AW'(COL) + AW'(t);
        word[B_IFIFO_WR]        = 1'b1;
      end
      S_W_LOAD: begin
        word[B_IFIFO_RD]        = 1'b1;
        word[B_LOAD]            = 1'b1;
      end
      S_W_HOLD:  word[B_LOAD]   = 1'b1;
      S_A_FETCH: begin
        word[B_CEN_X]           = 1'b0;
        word[B_AX_LSB +: AW]    = AW'(t);
        word[B_L0_WR]           = 1'b1;
      end
      S_EXEC: begin
        word[B_L0_RD]           = 1'b1;
        word[B_EXEC]            = 1'b1;
      end
      S_WB: begin
        if (ofifo_valid) begin
          word[B_OFIFO_RD]      = 1'b1;
          word[B_CEN_P]         = 1'b0;
          word[B_WEN_P]         = 1'b0;
          word[B_AP_LSB +: AW]  = AW'(kij) * AW'(LEN_NIJ) + AW'(t);
        end
      end
`ifdef CONV_SEQ_ACC_EN
      S_ACC_RD: begin
        if (t < T_ACC_END) begin
          word[B_CEN_P]         = 1'b0;
          word[B_AP_LSB +: AW]  = acc_addr;
        end
        if (t != '0) word[B_ACC] = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      t     <= '0;
      kij   <= '0;
      inst  <= IDLE_INST;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef CONV_SEQ_ACC_EN
      acc_clr     <= 1'b0;
      out_strobe  <= 1'b0;
      strobe_pend <= 1'b0;
      final_px    <= 1'b0;
`endif
    end else begin
      inst <= word;
      busy <= (state != S_IDLE) && (state != S_DONE);
      done <= (state == S_DONE);
`ifdef CONV_SEQ_ACC_EN
      // The strobe lands with the word after the last accumulate, hence the extra stage.
      acc_clr     <= (state == S_ACC_CLR);
      strobe_pend <= (state == S_ACC_RD) && (t == T_ACC_END);
      out_strobe  <= strobe_pend;
      if (state == S_IDLE)            final_px <= 1'b0;
      else if (acc_step && acc_last)  final_px <= 1'b1;
`endif
      case (state)
        S_IDLE: begin
          t   <= '0;
          kij <= '0;
          if (start) state <= S_W_FETCH;
        end
        S_W_FETCH:
          if (t == T_COL_END) begin t <= '0; state <= S_W_LOAD; end
          else t <= t + 16'd1;
        S_W_LOAD:
          if (t == T_COL_END) begin t <= '0; state <= S_W_HOLD; end
          else t <= t + 16'd1;
        S_W_HOLD:
          if (t == T_HOLD_END) begin t <= '0; state <= S_W_END; end
          else t <= t + 16'd1;
        S_W_END: state <= S_A_FETCH;
        S_A_FETCH:
          if (t == T_AF_END) begin t <= '0; state <= S_EXEC; end
          else t <= t + 16'd1;
        S_EXEC:
          if (t == T_EX_END) begin t <= '0; state <= S_WB; end
          else t <= t + 16'd1;
        S_WB:
          if (ofifo_valid) begin
            if (t == T_WB_END) begin
              t <= '0;
              if (kij == KIJ_LAST) begin
`ifdef CONV_SEQ_ACC_EN
                state <= S_ACC_CLR;
`else
                state <= S_DONE;
`endif
              end else begin
                kij   <= kij + 8'd1;
                state <= S_W_FETCH;
              end
            end else begin
              t <= t + 16'd1;
            end
          end
`ifdef CONV_SEQ_ACC_EN
        S_ACC_CLR: state <= S_ACC_RD;
        S_ACC_RD:
          if (t == T_ACC_END) begin
            t     <= '0;
            state <= final_px ? S_DONE : S_ACC_CLR;
          end else begin
            t <= t + 16'd1;
          end
`endif
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Scoreboard bench for conv_sequencer: spec-level model of the tile's instruction stream.
module tb_conv_sequencer;

  localparam int ROW = 8, COL = 8, IN_W = 6, K = 3, GAP = 10, W_BASE = 1024;
  localparam int NIJ = IN_W * IN_W, KIJ = K * K, O_W = IN_W - K + 1, ONIJ = O_W * O_W;
  localparam logic [33:0] IDLE = 34'h1_800C_0000;
`ifdef CONV_SEQ_ACC_EN
  localparam int EXP_CYC = 9 * 160 + 16 * 11;
  localparam int EXP_STB = ONIJ;
`else
  localparam int EXP_CYC = 9 * 160;
  localparam int EXP_STB = 0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, ofifo_valid, ov_at_edge;
  logic [33:0] inst;
  logic        acc_clr, out_strobe, busy, done;

  typedef struct { logic [37:0] v; bit stall; } exp_t;
  exp_t exp_q[$];
  int   checks = 0, errors = 0, strobe_cnt = 0;

  conv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
    .inst(inst), .acc_clr(acc_clr), .out_strobe(out_strobe), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ov_at_edge <= ofifo_valid;

  task automatic check(input string name, input logic [37:0] act, input logic [37:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic push(input logic [33:0] w, input bit clr, input bit stb, input bit dn, input bit stall);
    exp_t e;
    e.v = {~dn, dn, stb, clr, w};
    e.stall = stall;
    exp_q.push_back(e);
  endtask

  function automatic logic [33:0] ctrl(input logic [6:0] c);
    logic [33:0] w = IDLE;
    w[6:0] = c;
    return w;
  endfunction

  function automatic logic [33:0] xrd(input int a, input logic [6:0] c);
    logic [33:0] w = IDLE;
    w[19] = 1'b0;
    w[17:7] = 11'(a);
    w[6:0] = c;
    return w;
  endfunction

  function automatic logic [33:0] pwr(input int a);
    logic [33:0] w = IDLE;
    w[32] = 1'b0;
    w[31] = 1'b0;
    w[30:20] = 11'(a);
    w[6] = 1'b1;
    return w;
  endfunction

  // Expected stream for one stall-free tile; WB entries may be delayed by stalls.
  task automatic build_model();
    logic [33:0] w;
    for (int kij = 0; kij < KIJ; kij++) begin
      for (int t = 0; t < COL; t++) push(xrd(W_BASE + kij * COL + t, 7'b0100000), 0, 0, 0, 0);
      for (int t = 0; t < COL; t++) push(ctrl(7'b0010001), 0, 0, 0, 0);
      for (int t = 0; t < COL + GAP; t++) push(ctrl(7'b0000001), 0, 0, 0, 0);
      push(IDLE, 0, 0, 0, 0);
      for (int t = 0; t <= NIJ; t++) push(xrd(t, 7'b0000100), 0, 0, 0, 0);
      for (int t = 0; t < NIJ + ROW + COL; t++) push(ctrl(7'b0001010), 0, 0, 0, 0);
      for (int t = 0; t < NIJ; t++) push(pwr(kij * NIJ + t), 0, 0, 0, 1);
    end
`ifdef CONV_SEQ_ACC_EN
    for (int o = 0; o < ONIJ; o++) begin
      push(IDLE, 1, o > 0, 0, 0);
      for (int j = 0; j <= KIJ; j++) begin
        w = IDLE;
        if (j < KIJ) begin
          w[32] = 1'b0;
          w[30:20] = 11'(((o / O_W) + (j / K)) * IN_W + (o % O_W) + (j % K) + j * NIJ);
        end
        if (j >= 1) w[33] = 1'b1;
        push(w, 0, 0, 0, 0);
      end
    end
    push(IDLE, 0, 1, 1, 0);
`else
    push(IDLE, 0, 0, 1, 0);
`endif
  endtask

  task automatic monitor();
    exp_t h;
    logic [37:0] act, want;
    forever begin
      @(negedge clk);
      if (!reset) begin
        act = {busy, done, out_strobe, acc_clr, inst};
        if (out_strobe) strobe_cnt++;
        want = {4'b0000, IDLE};
        if ((busy || done) && exp_q.size() > 0) begin
          h = exp_q[0];
          if (h.stall && !ov_at_edge) want = {4'b1000, IDLE};
          else begin
            want = h.v;
            void'(exp_q.pop_front());
          end
        end
        check("stream", act, want);
      end
    end
  endtask

  task automatic drive_ov(input int mode);
    case (mode)
      0: ofifo_valid = 1'b1;
      1: ofifo_valid = ~ofifo_valid;
      default: ofifo_valid = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic run_tile(input int mode, input bit pulse, input int abort_at);
    int cyc, w, dcount;
    bit aborted;
    exp_q.delete();
    strobe_cnt = 0;
    build_model();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (!busy && w < 8) begin
      drive_ov(mode);
      @(posedge clk); #1;
      w++;
    end
    check("busy_rise", 38'(busy), 38'd1);
    cyc = 0;
    aborted = 0;
    while (!done && cyc < 6000 && !aborted) begin
      if (cyc == abort_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_idle", {busy, done, out_strobe, acc_clr, inst}, {4'b0000, IDLE});
        exp_q.delete();
        aborted = 1;
        @(posedge clk); #1;
        reset = 1'b0;
        dcount = 0;
        repeat (40) begin
          @(posedge clk); #1;
          if (done) dcount++;
        end
        check("abort_no_done", 38'(dcount), 38'd0);
      end else begin
        start = pulse && (cyc == 100 || cyc == 1000);
        drive_ov(mode);
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    if (!aborted) begin
      check("done_seen", 38'(done), 38'd1);
      if (mode == 0) check("tile_cycles", 38'(cyc), 38'(EXP_CYC));
      @(posedge clk); #1;
      check("queue_drained", 38'(exp_q.size()), 38'd0);
      check("strobe_count", 38'(strobe_cnt), 38'(EXP_STB));
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    ofifo_valid = 1'b1;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {busy, done, out_strobe, acc_clr, inst}, {4'b0000, IDLE});
    reset = 1'b0;
    @(posedge clk); #1;
    run_tile(0, 1, -1);
    repeat (5) @(posedge clk);
    #1;
    run_tile(1, 0, -1);
    repeat (5) @(posedge clk);
    #1;
    run_tile(0, 0, 570);
    run_tile(2, 1, -1);
    repeat (5) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
